// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and sequencer that lets two clients share one 16x8 single-port SRAM
// over a bidirectional data bus. Writes take IDLE+WRITE; reads take IDLE+READ+RCAP.
module sram_port_arbiter #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_w_r,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RCAP
    } state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic          winner, winner_nxt;
    logic          w_r_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] wdata_q, wdata_nxt;
    logic          ack0_nxt, ack1_nxt;
    logic [DW-1:0] rdata0_nxt, rdata1_nxt;
    logic          elig0, elig1, grant1;

    // A client is masked during its own ack cycle so a held request is not served twice.
    assign elig0 = req0 & ~ack0;
    assign elig1 = req1 & ~ack1;

    // Ties go to the client that was not served last.
    assign grant1 = elig1 & (~elig0 | ~last);

    // The arbiter owns the bus only while the SRAM is told to write.
    assign mem_data = mem_w_r ? wdata_q : {DW{1'bz}};

    always_ff @(posedge clk) begin
        // NOTE: every state register here uses <= so all of them update from the same pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            winner   <= 1'b0;
            mem_w_r  <= 1'b0;
            mem_addr <= '0;
            wdata_q  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            winner   <= winner_nxt;
            mem_w_r  <= w_r_nxt;
            mem_addr <= addr_nxt;
            wdata_q  <= wdata_nxt;
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            rdata0   <= rdata0_nxt;
            rdata1   <= rdata1_nxt;
        end
    end

    always_comb begin
        // NOTE: each output gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt  = state;
        last_nxt   = last;
        winner_nxt = winner;
        w_r_nxt    = mem_w_r;
        addr_nxt   = mem_addr;
        wdata_nxt  = wdata_q;
        ack0_nxt   = 1'b0;
        ack1_nxt   = 1'b0;
        rdata0_nxt = rdata0;
        rdata1_nxt = rdata1;

        case (state)
            IDLE: begin
                w_r_nxt = 1'b0;
                if (elig0 || elig1) begin
                    last_nxt   = grant1;
                    winner_nxt = grant1;
                    addr_nxt   = grant1 ? addr1  : addr0;
                    wdata_nxt  = grant1 ? wdata1 : wdata0;
                    if (grant1 ? we1 : we0) begin
                        w_r_nxt   = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            WRITE: begin
                w_r_nxt   = 1'b0;
                ack0_nxt  = ~winner;
                ack1_nxt  = winner;
                state_nxt = IDLE;
            end
            READ: begin
                state_nxt = RCAP;
            end
            RCAP: begin
                if (winner) rdata1_nxt = mem_data;
                else        rdata0_nxt = mem_data;
                ack0_nxt  = ~winner;
                ack1_nxt  = winner;
                state_nxt = IDLE;
            end
            default: begin
                w_r_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a behavioural SRAM on the shared bus, a transaction-level
// memory model for expected data, directed scenarios and a randomized two-client phase.
module tb_sram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_w_r;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;

    always #5 clk = ~clk;

    sram_port_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .mem_w_r  (mem_w_r),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    // The SRAM device: writes when w_r=1, otherwise registers a read and drives the bus.
    logic [DW-1:0] sram [16];
    logic [DW-1:0] sram_q;
    always @(posedge clk) begin
        if (mem_w_r) sram[mem_addr] <= mem_data;
        else         sram_q <= sram[mem_addr];
    end
    assign mem_data = mem_w_r ? {DW{1'bz}} : sram_q;

    // Reference state: what memory holds after each acknowledged operation.
    logic [DW-1:0] model_mem [16];
    bit            busy [2];
    bit            hold_req [2];
    logic          bwe [2];
    logic [AW-1:0] baddr [2];
    logic [DW-1:0] bdata [2];
    int            bstart [2];
    int            last_lat [2];
    int            ack_who [$];
    int            ack_cyc [$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;
    bit            rand_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input int c, input logic r);
        if (c == 0) begin
            req0 = r; we0 = bwe[0]; addr0 = baddr[0]; wdata0 = bdata[0];
        end else begin
            req1 = r; we1 = bwe[1]; addr1 = baddr[1]; wdata1 = bdata[1];
        end
    endtask

    task automatic start(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bwe[c]    = w;
        baddr[c]  = a;
        bdata[c]  = d;
        busy[c]   = 1'b1;
        bstart[c] = cyc;
        drive(c, 1'b1);
    endtask

    // Advance to the next falling edge and retire any acknowledged operations.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int c = 0; c < 2; c++) begin : retire
            logic          a;
            logic [DW-1:0] rd;
            int            lat;
            a  = (c == 0) ? ack0 : ack1;
            rd = (c == 0) ? rdata0 : rdata1;
            if (a === 1'b1) begin
                check("ack_owner", busy[c], 1);
                if (busy[c]) begin
                    lat         = cyc - bstart[c];
                    last_lat[c] = lat;
                    if (bwe[c]) model_mem[baddr[c]] = bdata[c];
                    else        check("rdata", rd, model_mem[baddr[c]]);
                    if (rand_mode) check("lat_bound", (lat >= 2 && lat <= 6), 1);
                    ack_who.push_back(c);
                    ack_cyc.push_back(cyc);
                    busy[c] = 1'b0;
                    if (!hold_req[c]) drive(c, 1'b0);
                end
            end else if (busy[c] && (cyc - bstart[c] > 20)) begin
                check("ack_timeout", cyc - bstart[c], 20);
                busy[c] = 1'b0;
                drive(c, 1'b0);
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (busy[0] || busy[1]); i++) tick();
    endtask

    task automatic run_op(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int exp_lat);
        tick();
        start(c, w, a, d);
        wait_idle();
        check(w ? "wr_latency" : "rd_latency", last_lat[c], exp_lat);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!mem_w_r) check("bus_nox", $isunknown(mem_data), 0);
            check("ack_excl", ack0 & ack1, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        for (int i = 0; i < 16; i++) begin
            sram[i]      = '0;
            model_mem[i] = '0;
        end
        sram_q = '0;
        for (int c = 0; c < 2; c++) begin
            busy[c] = 1'b0; hold_req[c] = 1'b0; bwe[c] = 1'b0;
            baddr[c] = '0; bdata[c] = '0; bstart[c] = 0; last_lat[c] = 0;
            drive(c, 1'b0);
        end

        // Reset with both clients requesting; client 0 must win the first tie.
        rst_n = 1'b0;
        start(0, 1'b1, 4'h5, 8'h5A);
        start(1, 1'b1, 4'h6, 8'h6B);
        repeat (3) begin
            tick();
            check("rst_w_r", mem_w_r, 0);
            check("rst_bus", mem_data, sram_q);
            check("rst_acks", {ack1, ack0}, 0);
            check("rst_rdata0", rdata0, 0);
            check("rst_rdata1", rdata1, 0);
        end
        mon_en = 1'b1;
        rst_n  = 1'b1;
        s = ack_who.size();
        wait_idle();
        check("rst_ack_count", ack_who.size() - s, 2);
        if (ack_who.size() >= s + 2) begin
            check("first_grant", ack_who[s], 0);
            check("second_grant", ack_who[s+1], 1);
        end

        // Single write then read by client 0.
        run_op(0, 1'b1, 4'h3, 8'hA5, 2);
        run_op(0, 1'b0, 4'h3, 8'h00, 3);
        check("rd_a5", rdata0, 8'hA5);

        // Client 1 holds its request through the ack cycle: no second operation.
        tick();
        hold_req[1] = 1'b1;
        start(1, 1'b1, 4'h9, 8'h99);
        wait_idle();
        hold_req[1] = 1'b0;
        check("mask_lat", last_lat[1], 2);
        tick();
        drive(1, 1'b0);
        check("mask_w_r", mem_w_r, 0);
        check("mask_ack", ack1, 0);
        repeat (3) begin
            tick();
            check("mask_w_r", mem_w_r, 0);
            check("mask_ack", ack1, 0);
        end

        // Simultaneous writes to the same word right after reset: 0 first, then 1.
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        s = ack_who.size();
        start(0, 1'b1, 4'h0, 8'h11);
        start(1, 1'b1, 4'h0, 8'h22);
        wait_idle();
        check("sim_ack_count", ack_who.size() - s, 2);
        if (ack_who.size() >= s + 2) begin
            check("sim_first", ack_who[s], 0);
            check("sim_second", ack_who[s+1], 1);
        end
        run_op(0, 1'b0, 4'h0, 8'h00, 3);
        check("rd_22", rdata0, 8'h22);

        // Both clients read continuously: strict alternation, one ack every 3 cycles.
        tick();
        s = ack_who.size();
        start(0, 1'b0, 4'($urandom), 8'h00);
        start(1, 1'b0, 4'($urandom), 8'h00);
        for (int i = 0; i < 60 && ack_who.size() - s < 8; i++) begin
            tick();
            for (int c = 0; c < 2; c++)
                if (!busy[c] && ack_who.size() - s < 8) start(c, 1'b0, 4'($urandom), 8'h00);
        end
        wait_idle();
        check("fair_count", ack_who.size() - s >= 8, 1);
        if (ack_who.size() >= s + 8) begin
            for (int k = 1; k < 8; k++) begin
                check("fair_alt", ack_who[s+k] != ack_who[s+k-1], 1);
                check("fair_gap", ack_cyc[s+k] - ack_cyc[s+k-1], 3);
            end
        end

        // Reset during RCAP abandons the read; the next read completes normally.
        run_op(0, 1'b0, 4'h3, 8'h00, 3);
        check("pre_rst_rd", rdata0, 8'hA5);
        tick();
        start(0, 1'b0, 4'h3, 8'h00);
        tick();
        tick();
        rst_n   = 1'b0;
        busy[0] = 1'b0;
        drive(0, 1'b0);
        tick();
        check("abort_ack", ack0, 0);
        check("abort_rdata", rdata0, 0);
        check("abort_w_r", mem_w_r, 0);
        rst_n = 1'b1;
        tick();
        check("abort_no_ack", ack0, 0);
        run_op(0, 1'b0, 4'h3, 8'h00, 3);
        check("post_rst_rd", rdata0, 8'hA5);

        // Randomized traffic from both clients against the memory model.
        rand_mode = 1'b1;
        repeat (400) begin
            tick();
            for (int c = 0; c < 2; c++)
                if (!busy[c] && $urandom_range(0, 2) != 0)
                    start(c, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
        end
        wait_idle();
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for the team's 16 x 8 single-port SRAM, which has a shared bidirectional data bus, a `w_r` write/read-bar select and a 4-bit address. It accepts independent read/write requests from two client ports and grants them round-robin. It drives the SRAM address, `w_r` and, during writes only, the data bus, then returns a one-cycle acknowledge and read data to the winning client. It sits between the clients and the SRAM, and shares `clk` with the SRAM.

## Interface
- `DW`, 8, data width; matches SRAM word.
- `AW`, 4, address width; matches SRAM depth of 16.

- `clk`  in  1  single clock; all state updates on rising edge; same clock as SRAM.
- `rst_n`  in  1  synchronous, active-low reset.
- `req0` / `req1`  in  1  client request; held with its `we`/`addr`/`wdata` until the matching ack.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  AW  target word address.
- `wdata0` / `wdata1`  in  DW  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse, registered.
- `rdata0` / `rdata1`  out  DW  read result, registered; valid when the ack for a read is high, and held until the next read by that client.
- `mem_w_r`  out  1  to SRAM `w_r`, registered.
- `mem_addr`  out  AW  to SRAM `addr`, registered.
- `mem_data`  inout  DW  to SRAM `data_io`; driven only while `mem_w_r`=1, otherwise high-Z.

## Operation
- FSM states: `IDLE`, `WRITE`, `READ`, `RCAP`.
- **`IDLE`**
  - Eligible requester i means `req_i`=1 and `ack_i`=0 in the same cycle. A request seen during its own ack cycle is not a new request.
  - If none is eligible, stay in `IDLE`.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the one that is not `last`.
  - On grant: `last` <= winner; latch `addr_i` into `mem_addr`; latch `wdata_i` into an internal write register.
  - Go to `WRITE` with `mem_w_r`<=1 if `we_i`=1. Otherwise go to `READ` with `mem_w_r`<=0.
- **`WRITE`**
  - `mem_data` is driven with the latched write data for the whole cycle. The SRAM writes at the closing edge.
  - At that edge: go to `IDLE`, `mem_w_r`<=0, `ack_winner`<=1.
- **`READ`**
  - `mem_w_r`=0 and `mem_addr` is stable. The SRAM loads its output register at the closing edge.
  - Go to `RCAP`.
- **`RCAP`**
  - The SRAM drives `mem_data`.
  - At the closing edge: `rdata_winner` <= `mem_data`, `ack_winner`<=1, go to `IDLE`.
- **Ack:** high for exactly one cycle, and only for the winner. The other ack stays 0.
- **Idle bus behaviour:** `mem_w_r`=0 when idle. The SRAM may perform don't-care reads, which have no side effect.
- **Bus ownership:** the arbiter never drives `mem_data` while `mem_w_r`=0, so there is no contention with the SRAM driver.
- **Fixed mapping:** `mem_addr` and the latched request are not re-sampled mid-operation. Client input changes after the grant are ignored until the next `IDLE` grant.
- **Reset values:**
  - state = `IDLE`, `last`=1 (so `req0` wins the first tie).
  - `mem_w_r`=0, `mem_addr`=0, `mem_data` = high-Z.
  - `ack0`=`ack1`=0, `rdata0`=`rdata1`=0, write register = 0.
- **Reset mid-operation:** the operation is abandoned and no ack is issued.
  - If reset is asserted at the edge closing `WRITE`, the SRAM still commits that write, because `w_r` was 1 during the cycle. Clients must treat the location as undefined.
  - An abandoned read leaves `rdata` at 0.

## Timing
- Edge E0 samples the request in `IDLE`. The grant occurs at E0.
- Write: SRAM commits at E1. `ack` is high in the cycle after E1. Latency from the sampling edge is 2 cycles.
- Read: SRAM loads at E1. `rdata` and `ack` are valid in the cycle after E2. Latency is 3 cycles.
- Throughput: one write per 2 cycles, one read per 3 cycles (the `IDLE` cycle is included in each).
- Back-to-back requests from the same client: the client drops `req` or presents new fields in the ack cycle. Its next request is eligible from the cycle after the ack.
- Both clients requesting continuously: strict alternation 0,1,0,1…. Neither client waits more than one other operation.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with both `req` high.
  - During reset: `mem_w_r`=0, `mem_data`=Z, both acks 0, both `rdata` 0.
  - After release: the first grant goes to client 0.
- **Single write then read by client 0:**
  - Stimulus: write `addr0`=4'h3, `wdata0`=8'hA5; then read `addr0`=4'h3.
  - Write: `ack0` 2 cycles after sampling.
  - Read: `ack0` 3 cycles after sampling with `rdata0`=8'hA5. `ack1` stays 0 throughout.
- **Simultaneous requests:**
  - Stimulus: client 0 writes 8'h11 to 4'h0 while client 1 writes 8'h22 to 4'h0, both asserted in the same cycle.
  - Client 0 is acked first, then client 1.
  - A subsequent read of 4'h0 returns 8'h22.
- **Round-robin fairness:** both clients read continuously for 8 operations.
  - Acks alternate 0,1,0,1… with a period of 3 cycles each.
  - No `mem_data` contention: never X when `mem_w_r`=0.
- **Ack-cycle masking:** client 1 holds `req1` one extra cycle through `ack1` while client 0 is idle.
  - No second operation is started for client 1. The FSM stays in `IDLE`.
- **Reset mid-read:** assert `rst_n`=0 in `RCAP`.
  - No ack is issued. `rdata` = 0. FSM = `IDLE`.
  - The next request completes normally with the correct data.
